// File: rtl/f2c_ring_dma_writer.sv
// FPGA-to-CPU ring DMA writer: packs a 64-bit stream into fixed-size write TLPs across a host ring
// of slots and posts the write pointer after each slot, throttled by the host read pointer.
module f2c_ring_dma_writer #(
  parameter int unsigned SLOT_LOG2  = 4,
  parameter int unsigned QW_PER_TLP = 16
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 enable_in,
  input  logic [31:0]          base_in,
  input  logic [SLOT_LOG2-1:0] rdPtr_in,
  input  logic [63:0]          f2cData_in,
  input  logic                 f2cValid_in,
  output logic                 f2cReady_out,
  output logic [63:0]          txData_out,
  output logic                 txValid_out,
  output logic                 txSop_out,
  output logic                 txEop_out,
  output logic [31:0]          txAddr_out,
  output logic [6:0]           txLen_out,
  input  logic                 txReady_in,
  output logic [SLOT_LOG2-1:0] wrPtr_out,
  output logic [31:0]          tlpCount_out,
  output logic                 busy_out
);

  localparam int unsigned N_SLOTS   = 1 << SLOT_LOG2;
  localparam int unsigned QW_LOG2   = $clog2(QW_PER_TLP);
  localparam int unsigned BEAT_W    = (QW_PER_TLP > 1) ? QW_LOG2 : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(QW_PER_TLP - 1);
  localparam logic [31:0] PTR_OFS  = 32'(N_SLOTS * QW_PER_TLP);
  localparam logic [6:0]  DATA_LEN = 7'(QW_PER_TLP);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    DATA       = 2'd2,
    PTR        = 2'd3
  } state_t;

  state_t                state;
  logic [31:0]           base_q;
  logic [SLOT_LOG2-1:0]  wr_ptr;
  logic [BEAT_W-1:0]     beat;
  logic [31:0]           tlp_count;
  logic [SLOT_LOG2-1:0]  wr_ptr_inc;
  logic                  data_hs;
  logic                  ptr_hs;

  // Slot index wraps naturally because the ring holds a power-of-two slot count.
  assign wr_ptr_inc = wr_ptr + SLOT_LOG2'(1);
  assign data_hs    = (state == DATA) && f2cValid_in && txReady_in;
  assign ptr_hs     = (state == PTR) && txReady_in;

  // Control FSM; a data TLP once entered always runs to its pointer post.
  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      base_q    <= '0;
      wr_ptr    <= '0;
      beat      <= '0;
      tlp_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          wr_ptr    <= '0;
          tlp_count <= '0;
          if (enable_in) begin
            base_q <= base_in;
            state  <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (!enable_in) begin
            wr_ptr    <= '0;
            tlp_count <= '0;
            state     <= IDLE;
          end else if (wr_ptr_inc != rdPtr_in) begin
            beat  <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (data_hs) begin
            if (beat == LAST_BEAT) begin
              state <= PTR;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        PTR: begin
          if (ptr_hs) begin
            if (enable_in) begin
              wr_ptr    <= wr_ptr_inc;
              tlp_count <= tlp_count + 32'd1;
              state     <= WAIT_SPACE;
            end else begin
              wr_ptr    <= '0;
              tlp_count <= '0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Transmit side: stream pass-through in DATA, single-qword pointer write in PTR.
  always_comb begin
    f2cReady_out = 1'b0;
    txValid_out  = 1'b0;
    txData_out   = '0;
    txSop_out    = 1'b0;
    txEop_out    = 1'b0;
    txAddr_out   = '0;
    txLen_out    = '0;
    case (state)
      DATA: begin
        txValid_out  = f2cValid_in;
        f2cReady_out = txReady_in;
        txData_out   = f2cData_in;
        if (beat == '0) begin
          txSop_out  = 1'b1;
          txAddr_out = base_q + (32'(wr_ptr) << QW_LOG2);
          txLen_out  = DATA_LEN;
        end
        if (beat == LAST_BEAT) begin
          txEop_out = 1'b1;
        end
      end
      PTR: begin
        txValid_out = 1'b1;
        txSop_out   = 1'b1;
        txEop_out   = 1'b1;
        txAddr_out  = base_q + PTR_OFS;
        txLen_out   = 7'd1;
        txData_out  = 64'(wr_ptr_inc);
      end
      default: ;
    endcase
  end

  assign wrPtr_out    = wr_ptr;
  assign tlpCount_out = tlp_count;
  assign busy_out     = (state != IDLE);

endmodule
